sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that sequences a read of both words of the platform system-ID slave: word 0 is the system ID, word 1 is the build timestamp.
- Compares the two words against build-time expected values and retries on mismatch.
- Latches both values and holds pass/fail status for boot firmware and the reset/LED logic.
- Sits between the boot sequencer (start/done handshake) and the sysid control slave in the platform interconnect.

Parameters:
- EXPECTED_ID, 32'h12345678: required system-ID word (address 0).
- EXPECTED_TS, 32'h5CB5EAE4: required timestamp word (address 1).
- READ_LATENCY, 0: cycles from read accept to readdata valid; legal range 0..3.
- MAX_ATTEMPTS, 3: total attempts before mismatch is final; legal range 1..15.
- TIMEOUT, 255: maximum cycles a read may stall on waitrequest; legal range 1..65535.

Ports:
- clock  in  1: single clock domain.
- reset  in  1: reset, asynchronous, active-high.
- start  in  1: one-cycle request to run a check; ignored while busy=1.
- avm_address  out  1: word select (0=ID, 1=timestamp).
- avm_read  out  1: read strobe.
- avm_waitrequest  in  1: slave stall.
- avm_readdata  in  32: read data.
- busy  out  1: check in progress.
- done  out  1: one-cycle pulse when a check finishes, for any outcome.
- id_ok  out  1: last captured ID == EXPECTED_ID.
- ts_ok  out  1: last captured timestamp == EXPECTED_TS.
- timeout_err  out  1: last check aborted on waitrequest timeout.
- id_value  out  32: last captured ID word.
- ts_value  out  32: last captured timestamp word.
- attempts  out  4: attempts used by the last or current check.

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous, active-high, named `reset`.
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation: abort immediately, avm_read=0 in the same cycle, no done pulse.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH.
- IDLE: on start=1, clear id_ok, ts_ok and timeout_err; set attempts=1, busy=1; go to RD_ID.
- RD_ID: avm_read=1, avm_address=0.
  - Read is accepted in the first cycle with waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata into id_value in the accept cycle, go to RD_TS.
  - READ_LATENCY>0: go to LAT_ID.
- LAT_ID: avm_read=0; count READ_LATENCY cycles; capture readdata in the last of them; go to RD_TS.
- RD_TS / LAT_TS: same as RD_ID / LAT_ID with avm_address=1; capture into ts_value; then go to CHECK.
- Outside RD_* states avm_read=0. avm_address holds its value between reads.
- Timeout:
  - Stall counter resets on entry to each RD_* state and increments on each cycle with waitrequest=1.
  - When it reaches TIMEOUT: drop avm_read, set timeout_err=1, go to FINISH. No retry on timeout.
- CHECK (1 cycle): register id_ok and ts_ok from the captured values.
  - Both ok: go to FINISH.
  - Otherwise, if attempts < MAX_ATTEMPTS: attempts+1, go to RD_ID (no idle gap).
  - Otherwise go to FINISH.
- FINISH (1 cycle): done=1, busy=0 from the next cycle; return to IDLE.
- Retained state: status and captured values hold until the next start or reset.
- Simultaneous events:
  - start in the FINISH cycle is ignored.
  - start in the cycle after FINISH is accepted.
- Latency: best case with READ_LATENCY=0 and no stalls is start → done in 4 cycles (RD_ID, RD_TS, CHECK, FINISH).
- attempts saturates at 15.

Test Plan:
- Zero-wait model returning 0x12345678 / 0x5CB5EAE4, READ_LATENCY=0: pulse start → address sequence 0,1; done on the 4th cycle after start; id_ok=ts_ok=1, attempts=1, timeout_err=0.
- Timestamp word returns 0x5CB5EAE5: → three attempts back-to-back; done with id_ok=1, ts_ok=0, attempts=3, ts_value=0x5CB5EAE5.
- Model returns wrong ID on attempt 1 only: → done with both ok, attempts=2, id_value=0x12345678.
- waitrequest held high, TIMEOUT=8: → avm_read drops after 8 stall cycles; timeout_err=1, done pulses once, attempts=1.
- READ_LATENCY=2 plus 3 waitrequest cycles on word 1:
  - data driven only 2 cycles after accept → correct capture, both ok.
  - a second start while busy is ignored.
- reset asserted in LAT_TS: → avm_read=0, busy=0, all outputs 0 without waiting for a clock edge; no done; a fresh start completes normally.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the platform system-ID slave (ID, then timestamp),
// compares both words against build-time values, retries on mismatch and holds status.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h12345678,
  parameter logic [31:0] EXPECTED_TS  = 32'h5CB5EAE4,
  parameter int          READ_LATENCY = 0,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  localparam bit         LAT_ZERO    = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LAST    = LAT_ZERO ? 2'd0 : 2'(READ_LATENCY - 1);
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0] ATTEMPT_MAX = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_CHECK, S_FINISH
  } state_t;

  state_t      r_state;
  logic        r_address;
  logic        r_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout_err;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic [3:0]  r_attempts;
  logic [15:0] r_stall;
  logic [1:0]  r_lat;

  logic       w_id_match;
  logic       w_ts_match;
  logic       w_stall_expired;
  logic       w_lat_last;
  logic [3:0] w_attempts_inc;

  assign w_id_match      = (r_id_value == EXPECTED_ID);
  assign w_ts_match      = (r_ts_value == EXPECTED_TS);
  assign w_stall_expired = (r_stall == STALL_LAST);
  assign w_lat_last      = (r_lat == LAT_LAST);
  assign w_attempts_inc  = (r_attempts == 4'd15) ? 4'd15 : r_attempts + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_address     <= 1'b0;
      r_read        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_id_value    <= 32'd0;
      r_ts_value    <= 32'd0;
      r_attempts    <= 4'd0;
      r_stall       <= 16'd0;
      r_lat         <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_attempts    <= 4'd1;
            r_busy        <= 1'b1;
            r_read        <= 1'b1;
            r_address     <= 1'b0;
            r_stall       <= 16'd0;
            r_state       <= S_RD_ID;
          end
        end
        S_RD_ID: begin
          if (!avm_waitrequest) begin
            r_lat <= 2'd0;
            if (LAT_ZERO) begin
              r_id_value <= avm_readdata;
              r_address  <= 1'b1;
              r_stall    <= 16'd0;
              r_state    <= S_RD_TS;
            end else begin
              r_read  <= 1'b0;
              r_state <= S_LAT_ID;
            end
          end else if (w_stall_expired) begin
            r_read        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_LAT_ID: begin
          // Data is valid only in the final latency cycle; earlier cycles are ignored.
          if (w_lat_last) begin
            r_id_value <= avm_readdata;
            r_read     <= 1'b1;
            r_address  <= 1'b1;
            r_stall    <= 16'd0;
            r_state    <= S_RD_TS;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_RD_TS: begin
          if (!avm_waitrequest) begin
            r_read <= 1'b0;
            r_lat  <= 2'd0;
            if (LAT_ZERO) begin
              r_ts_value <= avm_readdata;
              r_state    <= S_CHECK;
            end else begin
              r_state <= S_LAT_TS;
            end
          end else if (w_stall_expired) begin
            r_read        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_LAT_TS: begin
          if (w_lat_last) begin
            r_ts_value <= avm_readdata;
            r_state    <= S_CHECK;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_CHECK: begin
          r_id_ok <= w_id_match;
          r_ts_ok <= w_ts_match;
          if ((w_id_match && w_ts_match) || (r_attempts >= ATTEMPT_MAX)) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_attempts <= w_attempts_inc;
            r_read     <= 1'b1;
            r_address  <= 1'b0;
            r_stall    <= 16'd0;
            r_state    <= S_RD_ID;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_address = r_address;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout_err = r_timeout_err;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign attempts    = r_attempts;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a zero-latency instance (A) and a two-cycle
// latency instance (B), each driven by a small behavioural sysid slave model.
module tb_sysid_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b;

  logic        addr_a, read_a, wr_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a;
  logic [31:0] rdata_a, id_val_a, ts_val_a;
  logic [3:0]  att_a;

  logic        addr_b, read_b, wr_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b;
  logic [31:0] rdata_b, id_val_b, ts_val_b;
  logic [3:0]  att_b;

  sysid_checker #(.READ_LATENCY(0), .MAX_ATTEMPTS(3), .TIMEOUT(8)) u_dut_a (
    .clock(clk), .reset(rst), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout_err(to_a),
    .id_value(id_val_a), .ts_value(ts_val_a), .attempts(att_a)
  );

  sysid_checker #(.READ_LATENCY(2), .MAX_ATTEMPTS(3), .TIMEOUT(8)) u_dut_b (
    .clock(clk), .reset(rst), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout_err(to_b),
    .id_value(id_val_b), .ts_value(ts_val_b), .attempts(att_b)
  );

  // Slave A: zero latency, optional bad ID on the first accepted ID read.
  logic [31:0] ts_word_a = 32'h5CB5EAE4;
  logic        bad_first_a = 1'b0;
  logic        clr_a = 1'b0;
  int          id_reads_a = 0;
  always @(posedge clk) begin
    if (clr_a) id_reads_a <= 0;
    else if (read_a && !wr_a && !addr_a) id_reads_a <= id_reads_a + 1;
  end
  assign rdata_a = addr_a ? ts_word_a :
                   ((bad_first_a && id_reads_a == 0) ? 32'h0BADF00D : 32'h12345678);

  // Slave B: 3 stall cycles on word 1, data valid only 2 cycles after accept.
  logic p0_b = 1'b0, p1_b = 1'b0, pa0_b = 1'b0, pa1_b = 1'b0;
  int   stall_b = 0;
  assign wr_b = read_b && addr_b && (stall_b < 3);
  always @(posedge clk) begin
    p0_b  <= read_b && !wr_b;
    pa0_b <= addr_b;
    p1_b  <= p0_b;
    pa1_b <= pa0_b;
    if (read_b && addr_b) begin
      if (wr_b) stall_b <= stall_b + 1;
    end else begin
      stall_b <= 0;
    end
  end
  assign rdata_b = p1_b ? (pa1_b ? 32'h5CB5EAE4 : 32'h12345678) : 32'hDEADBEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge of cycle 1 (first cycle after start was sampled).
  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Caller is at cycle 'first'; cyc returns the cycle index where done is seen, -1 on expiry.
  task automatic wait_done(input bit sel, input int first, output int cyc);
    cyc = -1;
    for (int c = first; c < first + 200; c++) begin
      if (sel ? done_b : done_a) begin
        cyc = c;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int cyc;
  int seen;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; wr_a = 1'b0;
    step(3);
    check("reset_busy", busy_a, 1'b0);
    check("reset_read", read_a, 1'b0);
    check("reset_attempts", att_a, 4'd0);
    check("reset_id_value", id_val_a, 32'd0);
    rst = 1'b0;
    step(2);

    // Best case: RD_ID, RD_TS, CHECK, FINISH.
    pulse_start(1'b0);
    check("t1_c1_read", read_a, 1'b1);
    check("t1_c1_addr", addr_a, 1'b0);
    step(1);
    check("t1_c2_addr", addr_a, 1'b1);
    check("t1_c2_read", read_a, 1'b1);
    step(1);
    check("t1_c3_read", read_a, 1'b0);
    check("t1_c3_done", done_a, 1'b0);
    step(1);
    check("t1_c4_done", done_a, 1'b1);
    check("t1_id_ok", id_ok_a, 1'b1);
    check("t1_ts_ok", ts_ok_a, 1'b1);
    check("t1_attempts", att_a, 4'd1);
    check("t1_timeout", to_a, 1'b0);
    check("t1_id_value", id_val_a, 32'h12345678);
    start_a = 1'b1;                       // start during FINISH: ignored
    step(1);
    check("t1_finish_start_ignored", busy_a, 1'b0);
    step(1);                              // start held one more cycle: accepted
    start_a = 1'b0;
    check("t1_after_finish_accept", busy_a, 1'b1);
    check("t1_after_finish_read", read_a, 1'b1);
    wait_done(1'b0, 1, cyc);
    check("t1_second_latency", cyc, 4);
    $display("[TB] zero-wait check: done at cycle %0d", cyc);
    step(2);

    // Timestamp mismatch: three attempts back to back.
    ts_word_a = 32'h5CB5EAE5;
    pulse_start(1'b0);
    wait_done(1'b0, 1, cyc);
    check("t2_latency", cyc, 10);
    check("t2_id_ok", id_ok_a, 1'b1);
    check("t2_ts_ok", ts_ok_a, 1'b0);
    check("t2_attempts", att_a, 4'd3);
    check("t2_ts_value", ts_val_a, 32'h5CB5EAE5);
    $display("[TB] ts mismatch: done at cycle %0d attempts %0d", cyc, att_a);
    ts_word_a = 32'h5CB5EAE4;
    step(2);

    // Wrong ID on the first attempt only.
    bad_first_a = 1'b1;
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    pulse_start(1'b0);
    wait_done(1'b0, 1, cyc);
    check("t3_latency", cyc, 7);
    check("t3_id_ok", id_ok_a, 1'b1);
    check("t3_ts_ok", ts_ok_a, 1'b1);
    check("t3_attempts", att_a, 4'd2);
    check("t3_id_value", id_val_a, 32'h12345678);
    $display("[TB] first-id bad: done at cycle %0d attempts %0d", cyc, att_a);
    bad_first_a = 1'b0;
    step(2);

    // waitrequest stuck high with TIMEOUT=8.
    wr_a = 1'b1;
    pulse_start(1'b0);
    step(7);
    check("t4_c8_read", read_a, 1'b1);
    step(1);
    check("t4_c9_read", read_a, 1'b0);
    check("t4_c9_done", done_a, 1'b1);
    check("t4_timeout_err", to_a, 1'b1);
    check("t4_attempts", att_a, 4'd1);
    wr_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (done_a) seen++;
    end
    check("t4_extra_done", seen, 0);
    $display("[TB] timeout: timeout_err %0d", to_a);

    // Latency 2, 3 stalls on word 1, second start ignored while busy.
    pulse_start(1'b1);
    step(4);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    wait_done(1'b1, 6, cyc);
    check("t5_latency", cyc, 11);
    check("t5_id_value", id_val_b, 32'h12345678);
    check("t5_ts_value", ts_val_b, 32'h5CB5EAE4);
    check("t5_id_ok", id_ok_b, 1'b1);
    check("t5_ts_ok", ts_ok_b, 1'b1);
    check("t5_attempts", att_b, 4'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (done_b) seen++;
    end
    check("t5_extra_done", seen, 0);
    check("t5_busy_after", busy_b, 1'b0);
    $display("[TB] latency2: done at cycle %0d", cyc);

    // Asynchronous reset while in LAT_TS (cycle 8).
    pulse_start(1'b1);
    step(7);
    check("t6_pre_busy", busy_b, 1'b1);
    check("t6_pre_addr", addr_b, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_read", read_b, 1'b0);
    check("t6_rst_busy", busy_b, 1'b0);
    check("t6_rst_addr", addr_b, 1'b0);
    check("t6_rst_attempts", att_b, 4'd0);
    check("t6_rst_id_value", id_val_b, 32'd0);
    check("t6_rst_id_ok", id_ok_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (done_b) seen++;
    end
    check("t6_no_done", seen, 0);
    pulse_start(1'b1);
    wait_done(1'b1, 1, cyc);
    check("t6_fresh_latency", cyc, 11);
    check("t6_fresh_id_ok", id_ok_b, 1'b1);
    check("t6_fresh_ts_ok", ts_ok_b, 1'b1);
    $display("[TB] reset in LAT_TS then fresh check: done at cycle %0d", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
